// File: rtl/magnitude_squared_pkg.sv
// Shared types and helpers for the iterative complex magnitude-squared unit.
package magnitude_squared_pkg;

  // Default output width; each signed input component is half of it.
  localparam int DEFAULT_BIT_WIDTH = 32;

  // Widest component the magnitude helper handles (BIT_WIDTH up to 128).
  localparam int ABS_MAX_W = 64;

  // Control states: waiting for a sample, iterating, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned magnitude of a sign-extended component. The caller truncates the
  // result to HALF bits; |-2^(HALF-1)| = 2^(HALF-1) still fits in HALF bits
  // once viewed as unsigned.
  function automatic logic [ABS_MAX_W-1:0] abs_half(input logic signed [ABS_MAX_W-1:0] x);
    logic signed [ABS_MAX_W-1:0] neg;
    neg = -x;
    return x[ABS_MAX_W-1] ? neg : x;
  endfunction

endpackage

// File: rtl/magnitude_squared_if.sv
// Valid/ready message channel used on both sides of the magnitude-squared unit.
interface magnitude_squared_if
  import magnitude_squared_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
);

  logic [BIT_WIDTH-1:0] msg;
  logic                 val;
  logic                 rdy;

  // Producer drives message and valid, consumer answers with ready.
  modport master (output msg, output val, input rdy);
  modport slave  (input msg, input val, output rdy);

endinterface

// File: rtl/magnitude_squared_dpath.sv
// Datapath for re^2 + im^2: two shift-add multipliers sharing one accumulator,
// each retiring one multiplier bit per step.
module magnitude_squared_dpath
  import magnitude_squared_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          step,
  input  logic signed [BIT_WIDTH/2-1:0] re,
  input  logic signed [BIT_WIDTH/2-1:0] im,
  output logic        [BIT_WIDTH-1:0]   acc,
  output logic                          cnt_zero
);

  localparam int HALF  = BIT_WIDTH / 2;
  localparam int CNT_W = $clog2(HALF);

  // Multiplier bits still to consume (shifting right).
  logic [HALF-1:0]      mr;
  logic [HALF-1:0]      mi;
  // Multiplicands aligned to the current bit weight (shifting left).
  logic [BIT_WIDTH-1:0] ar;
  logic [BIT_WIDTH-1:0] ai;
  logic [CNT_W-1:0]     cnt;

  logic [HALF-1:0]      mag_re;
  logic [HALF-1:0]      mag_im;
  logic [BIT_WIDTH-1:0] pp_re;
  logic [BIT_WIDTH-1:0] pp_im;
  logic [BIT_WIDTH-1:0] acc_next;

  // Component magnitudes and the two partial products for this step. The sum
  // is bounded by 2^(BIT_WIDTH-1), so BIT_WIDTH bits never wrap.
  always_comb begin
    mag_re   = HALF'(abs_half(ABS_MAX_W'(re)));
    mag_im   = HALF'(abs_half(ABS_MAX_W'(im)));
    pp_re    = mr[0] ? ar : '0;
    pp_im    = mi[0] ? ai : '0;
    acc_next = acc + pp_re + pp_im;
  end

  // Load operands on accept, then shift and accumulate once per CALC cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mr  <= '0;
      mi  <= '0;
      ar  <= '0;
      ai  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      mr  <= mag_re;
      mi  <= mag_im;
      ar  <= BIT_WIDTH'(mag_re);
      ai  <= BIT_WIDTH'(mag_im);
      acc <= '0;
      cnt <= CNT_W'(HALF - 1);
    end else if (step) begin
      mr  <= mr >> 1;
      mi  <= mi >> 1;
      ar  <= ar << 1;
      ai  <= ai << 1;
      acc <= acc_next;
      cnt <= cnt - 1'b1;
    end
  end

  // The step taken while cnt is zero is the last of the HALF steps.
  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/magnitude_squared.sv
// Iterative complex magnitude-squared unit: accepts {re, im} over valid/ready,
// returns the exact unsigned re^2 + im^2 HALF+1 cycles later.
module magnitude_squared
  import magnitude_squared_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  magnitude_squared_if.slave    recv,
  magnitude_squared_if.master   send
);

  localparam int HALF = BIT_WIDTH / 2;

  // Reject widths the datapath cannot represent at elaboration time.
  if ((BIT_WIDTH % 2) != 0 || BIT_WIDTH < 4 || HALF > ABS_MAX_W) begin : g_bad_width
    $error("magnitude_squared: BIT_WIDTH must be even, >= 4 and <= 2*ABS_MAX_W");
  end

  state_t                  state;
  logic                    in_rdy;
  logic                    out_val;
  logic                    load;
  logic                    step;
  logic                    cnt_zero;
  logic signed [HALF-1:0]  re;
  logic signed [HALF-1:0]  im;
  logic [BIT_WIDTH-1:0]    acc;

  assign re = recv.msg[BIT_WIDTH-1:HALF];
  assign im = recv.msg[HALF-1:0];

  // Moore outputs decoded from state only; reset forces IDLE values at once.
  assign in_rdy  = (state == IDLE);
  assign out_val = (state == DONE);

  assign load = recv.val && in_rdy;
  assign step = (state == CALC);

  // Control FSM: accept in IDLE, iterate in CALC, hold the result in DONE.
  // A new sample is never taken in DONE, so recv_rdy rises only after the
  // output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (recv.val && in_rdy)   state <= CALC;
        CALC:    if (cnt_zero)             state <= DONE;
        DONE:    if (out_val && send.rdy)  state <= IDLE;
        default:                           state <= IDLE;
      endcase
    end
  end

  magnitude_squared_dpath #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_dpath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .re       (re),
    .im       (im),
    .acc      (acc),
    .cnt_zero (cnt_zero)
  );

  assign recv.rdy = in_rdy;
  assign send.val = out_val;
  assign send.msg = acc;

endmodule

// File: tb/tb_magnitude_squared.sv
// Scoreboard bench for magnitude_squared: expected re^2 + im^2 values are
// queued when a sample is accepted and compared when send_val is observed.
module tb_magnitude_squared;
  import magnitude_squared_pkg::*;

  localparam int BW   = 32;
  localparam int HALF = BW / 2;

  logic clk = 1'b0;
  logic reset;

  magnitude_squared_if #(.BIT_WIDTH(BW)) recv_if ();
  magnitude_squared_if #(.BIT_WIDTH(BW)) send_if ();

  magnitude_squared #(.BIT_WIDTH(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .recv  (recv_if),
    .send  (send_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_q[$];

  function automatic logic [BW-1:0] model(input int re, input int im);
    longint r;
    longint i;
    r = re;
    i = im;
    return BW'(r * r + i * i);
  endfunction

  function automatic logic [BW-1:0] pack(input int re, input int im);
    logic [HALF-1:0] r;
    logic [HALF-1:0] i;
    r = HALF'(re);
    i = HALF'(im);
    return {r, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a sample and step through its accepting edge; queue its result.
  task automatic accept(input int re, input int im, input bit keep_val, output bit ok);
    int n = 0;
    recv_if.msg = pack(re, im);
    recv_if.val = 1'b1;
    while (recv_if.rdy !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    ok = (recv_if.rdy === 1'b1);
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: recv_rdy=%b after %0d cycles, required 1", recv_if.rdy, n);
      recv_if.val = 1'b0;
    end else begin
      tick();
      exp_q.push_back(model(re, im));
      if (!keep_val) recv_if.val = 1'b0;
    end
  endtask

  // Wait (bounded) for send_val; edges counts clock edges waited.
  task automatic wait_done(output int edges, output bit ok);
    edges = 0;
    while (send_if.val !== 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
    ok = (send_if.val === 1'b1);
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: send_val=%b after %0d cycles, required 1", send_if.val, edges);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    recv_if.msg = '0;
    recv_if.val = 1'b0;
    send_if.rdy = 1'b0;
    #2;
    if (send_if.val !== 1'b0) begin errors++; $display("FAIL reset_send_val: got %b required 0", send_if.val); end
    checks++;
    if (recv_if.rdy !== 1'b1) begin errors++; $display("FAIL reset_recv_rdy: got %b required 1", recv_if.rdy); end
    checks++;
    if (send_if.msg !== '0) begin errors++; $display("FAIL reset_send_msg: got %h required 0", send_if.msg); end
    checks++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();
    if (recv_if.rdy !== 1'b1) begin errors++; $display("FAIL post_reset_recv_rdy: got %b required 1", recv_if.rdy); end
    checks++;
    if (send_if.val !== 1'b0 || send_if.msg !== '0) begin
      errors++;
      $display("FAIL post_reset_send: val=%b msg=%h required val=0 msg=0", send_if.val, send_if.msg);
    end
    checks++;
  endtask

  task automatic test_basic();
    bit ok;
    int edges = 0;
    int bad_rdy = 0;
    logic [BW-1:0] exp;
    send_if.rdy = 1'b1;
    accept(3, 4, 1'b0, ok);
    if (ok) begin
      while (send_if.val !== 1'b1 && edges < 200) begin
        if (recv_if.rdy !== 1'b0) bad_rdy++;
        tick();
        edges++;
      end
      if (recv_if.rdy !== 1'b0) bad_rdy++;
      if (bad_rdy != 0) begin errors++; $display("FAIL basic_recv_rdy_busy: got %0d cycles with recv_rdy!=0 required 0", bad_rdy); end
      checks++;
      // Sample accepted in cycle 0 shows send_val in cycle HALF+1, i.e. HALF edges later.
      if (edges != HALF) begin errors++; $display("FAIL basic_latency: got %0d edges required %0d", edges, HALF); end
      checks++;
      exp = exp_q.pop_front();
      if (send_if.msg !== exp) begin errors++; $display("FAIL basic_result: got %0d required %0d", send_if.msg, exp); end
      checks++;
      tick();
      if (send_if.val !== 1'b0 || recv_if.rdy !== 1'b1) begin
        errors++;
        $display("FAIL basic_after_handshake: send_val=%b recv_rdy=%b required 0 and 1", send_if.val, recv_if.rdy);
      end
      checks++;
    end
  endtask

  task automatic test_extremes();
    int re_t[3] = '{-32768, 32767, 0};
    int im_t[3] = '{-32768, 0, 0};
    bit ok;
    int edges;
    logic [BW-1:0] exp;
    send_if.rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      accept(re_t[k], im_t[k], 1'b0, ok);
      if (ok) begin
        wait_done(edges, ok);
        exp = exp_q.pop_front();
        if (ok) begin
          if (send_if.msg !== exp) begin
            errors++;
            $display("FAIL extreme_%0d: re=%0d im=%0d got %h required %h", k, re_t[k], im_t[k], send_if.msg, exp);
          end
          checks++;
        end
        tick();
      end
    end
  endtask

  task automatic test_sign_symmetry();
    int re_t[3] = '{-5, 5, -5};
    int im_t[3] = '{12, -12, -12};
    bit ok;
    int edges;
    logic [BW-1:0] exp;
    send_if.rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      accept(re_t[k], im_t[k], 1'b0, ok);
      if (ok) begin
        wait_done(edges, ok);
        exp = exp_q.pop_front();
        if (ok) begin
          if (send_if.msg !== exp) begin
            errors++;
            $display("FAIL sign_%0d: re=%0d im=%0d got %0d required %0d", k, re_t[k], im_t[k], send_if.msg, exp);
          end
          checks++;
        end
        tick();
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int edges;
    int bad_val = 0;
    int bad_msg = 0;
    int bad_rdy = 0;
    logic [BW-1:0] exp;
    send_if.rdy = 1'b0;
    accept(3, 4, 1'b1, ok);
    if (ok) begin
      // A different message with recv_val held must not be sampled.
      recv_if.msg = pack(100, 100);
      wait_done(edges, ok);
      exp = exp_q.pop_front();
      if (ok) begin
        for (int c = 0; c < 10; c++) begin
          if (send_if.val !== 1'b1) bad_val++;
          if (send_if.msg !== exp) bad_msg++;
          if (recv_if.rdy !== 1'b0) bad_rdy++;
          tick();
        end
        if (bad_val != 0) begin errors++; $display("FAIL bp_send_val_hold: got %0d cycles low required 0", bad_val); end
        checks++;
        if (bad_msg != 0) begin errors++; $display("FAIL bp_send_msg_hold: got %0d cycles != %0d required 0", bad_msg, exp); end
        checks++;
        if (bad_rdy != 0) begin errors++; $display("FAIL bp_recv_rdy_low: got %0d cycles high required 0", bad_rdy); end
        checks++;
        send_if.rdy = 1'b1;
        tick();
        if (send_if.val !== 1'b0 || recv_if.rdy !== 1'b1) begin
          errors++;
          $display("FAIL bp_release: send_val=%b recv_rdy=%b required 0 and 1", send_if.val, recv_if.rdy);
        end
        checks++;
      end
    end
    recv_if.val = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc_edge[2] = '{0, 0};
    logic [BW-1:0] got[2];
    logic [BW-1:0] exp;
    int phase = 0;
    int outs = 0;
    bit pending = 1'b0;
    send_if.rdy = 1'b1;
    recv_if.msg = pack(1, 1);
    recv_if.val = 1'b1;
    got[0] = '0;
    got[1] = '0;
    for (int n = 0; n < 3 * (HALF + 2); n++) begin
      if (send_if.val === 1'b1) begin
        if (outs < 2) got[outs] = send_if.msg;
        outs++;
      end
      if (pending) begin
        if (phase == 1) recv_if.msg = pack(2, 2);
        else            recv_if.val = 1'b0;
        pending = 1'b0;
      end
      if (recv_if.rdy === 1'b1 && recv_if.val === 1'b1 && phase < 2) begin
        acc_edge[phase] = n + 1;
        exp_q.push_back(phase == 0 ? model(1, 1) : model(2, 2));
        phase++;
        pending = 1'b1;
      end
      tick();
    end
    recv_if.val = 1'b0;
    if (phase != 2) begin errors++; $display("FAIL b2b_accepts: got %0d required 2", phase); end
    checks++;
    if (acc_edge[1] - acc_edge[0] != HALF + 2) begin
      errors++;
      $display("FAIL b2b_accept_gap: got %0d cycles required %0d", acc_edge[1] - acc_edge[0], HALF + 2);
    end
    checks++;
    if (outs != 2) begin errors++; $display("FAIL b2b_send_val_cycles: got %0d required 2", outs); end
    checks++;
    for (int k = 0; k < 2; k++) begin
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        if (got[k] !== exp) begin errors++; $display("FAIL b2b_result_%0d: got %0d required %0d", k, got[k], exp); end
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    int edges;
    int stale = 0;
    logic [BW-1:0] exp;
    send_if.rdy = 1'b1;
    accept(1000, -2000, 1'b0, ok);
    if (ok) begin
      void'(exp_q.pop_back());
      repeat (7) tick();
      #1;
      reset = 1'b0;
      #1;
      if (send_if.val !== 1'b0) begin errors++; $display("FAIL midrst_send_val: got %b required 0", send_if.val); end
      checks++;
      if (recv_if.rdy !== 1'b1) begin errors++; $display("FAIL midrst_recv_rdy: got %b required 1", recv_if.rdy); end
      checks++;
      if (send_if.msg !== '0) begin errors++; $display("FAIL midrst_send_msg: got %h required 0", send_if.msg); end
      checks++;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tick();
      for (int c = 0; c < 5; c++) begin
        if (send_if.val !== 1'b0) stale++;
        tick();
      end
      if (stale != 0) begin errors++; $display("FAIL midrst_stale_output: got %0d send_val cycles required 0", stale); end
      checks++;
      accept(6, 8, 1'b0, ok);
      if (ok) begin
        wait_done(edges, ok);
        exp = exp_q.pop_front();
        if (ok) begin
          if (edges != HALF) begin errors++; $display("FAIL midrst_latency: got %0d edges required %0d", edges, HALF); end
          checks++;
          if (send_if.msg !== exp) begin errors++; $display("FAIL midrst_result: got %0d required %0d", send_if.msg, exp); end
          checks++;
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_sign_symmetry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size()); end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
